// File: rtl/sub128_seq.sv
// sub128_seq: multi-cycle 128-bit subtractor d = a - b - bi, SLICE bits per cycle
// with a registered borrow chain and a start/busy/done handshake.
module sub128_seq #(
    parameter int SLICE = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [127:0] a,
    input  logic [127:0] b,
    input  logic         bi,
    output logic         busy,
    output logic         done,
    output logic [127:0] d,
    output logic         bo,
    output logic         z,
    output logic         v
);
    localparam int N  = 128 / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic [127:0]     a_q, b_q;
    logic             brw, nz, last, accept, c;
    logic [7:0]       base;
    logic [SLICE-1:0] a_k, b_k, s;

    assign base = 8'(cnt) * 8'(SLICE);
    assign a_k  = a_q[base +: SLICE];
    assign b_k  = b_q[base +: SLICE];
    // a - b - borrow as a + ~b + ~borrow; carry out is the inverted borrow
    assign {c, s} = {1'b0, a_k} + {1'b0, ~b_k} + {{SLICE{1'b0}}, ~brw};
    assign last = (cnt == CW'(N - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = (state == IDLE) ? (start ? RUN : IDLE) : (last ? IDLE : RUN);
    end

    always_comb begin
        busy   = (state == RUN);
        accept = (state == IDLE) && start;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q  <= '0;
            b_q  <= '0;
            brw  <= 1'b0;
            nz   <= 1'b0;
            cnt  <= '0;
            done <= 1'b0;
            d    <= '0;
            bo   <= 1'b0;
            z    <= 1'b0;
            v    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                a_q <= a;
                b_q <= b;
                brw <= bi;
                nz  <= 1'b0;
                cnt <= '0;
            end else if (busy) begin
                d[base +: SLICE] <= s;
                brw <= ~c;
                nz  <= nz | (|s);
                cnt <= last ? '0 : cnt + CW'(1);
                if (last) begin
                    done <= 1'b1;
                    bo   <= ~c;
                    z    <= ~(nz | (|s));
                    v    <= (a_q[127] ^ b_q[127]) & (a_q[127] ^ s[SLICE-1]);
                end
            end
        end
    end
endmodule

// File: tb/tb_sub128_seq.sv
// tb_sub128_seq: directed vector table plus handshake corner sequences for
// SLICE = 4, 32 and 128 instances driven from shared inputs.
module tb_sub128_seq;
    logic         clk = 1'b0, reset_n = 1'b0, start = 1'b0, bi = 1'b0;
    logic [127:0] a = '0, b = '0;
    logic [2:0]   busy_w, done_w, bo_w, z_w, v_w;
    logic [127:0] d_w [3];
    int passed = 0, total = 0;
    localparam int NS [3] = '{32, 4, 1};
    localparam int SL [3] = '{4, 32, 128};
    localparam logic [127:0] ONES = {128{1'b1}};

    always #5 clk = ~clk;

    sub128_seq #(.SLICE(4)) u4 (.clk(clk), .reset_n(reset_n), .start(start), .a(a), .b(b), .bi(bi),
        .busy(busy_w[0]), .done(done_w[0]), .d(d_w[0]), .bo(bo_w[0]), .z(z_w[0]), .v(v_w[0]));
    sub128_seq #(.SLICE(32)) u32 (.clk(clk), .reset_n(reset_n), .start(start), .a(a), .b(b), .bi(bi),
        .busy(busy_w[1]), .done(done_w[1]), .d(d_w[1]), .bo(bo_w[1]), .z(z_w[1]), .v(v_w[1]));
    sub128_seq #(.SLICE(128)) u128 (.clk(clk), .reset_n(reset_n), .start(start), .a(a), .b(b), .bi(bi),
        .busy(busy_w[2]), .done(done_w[2]), .d(d_w[2]), .bo(bo_w[2]), .z(z_w[2]), .v(v_w[2]));

    typedef struct {
        logic [127:0] a, b;
        logic         bi;
        logic [127:0] d;
        logic         bo, z, v;
    } vec_t;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t model(input logic [127:0] x, input logic [127:0] y, input logic bin);
        vec_t t;
        logic [128:0] r;
        r = {1'b0, x} - {1'b0, y} - {128'd0, bin};
        t.a = x; t.b = y; t.bi = bin;
        t.d = r[127:0];
        t.bo = r[128];
        t.z = (r[127:0] == '0);
        t.v = (x[127] ^ y[127]) & (x[127] ^ r[127]);
        return t;
    endfunction

    task automatic run_op(input vec_t t, input string tag);
        int nd [3];
        int kd [3];
        logic [127:0] dd [3];
        logic [2:0] fl [3];
        nd = '{0, 0, 0};
        kd = '{0, 0, 0};
        a = t.a; b = t.b; bi = t.bi; start = 1'b1;
        tick;
        start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick;
            for (int i = 0; i < 3; i++)
                if (done_w[i]) begin
                    nd[i]++;
                    kd[i] = k;
                    dd[i] = d_w[i];
                    fl[i] = {bo_w[i], z_w[i], v_w[i]};
                end
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s s%0d done_count", tag, SL[i]), 128'(nd[i]), 128'd1);
            chk($sformatf("%s s%0d latency", tag, SL[i]), 128'(kd[i]), 128'(NS[i]));
            chk($sformatf("%s s%0d d", tag, SL[i]), dd[i], t.d);
            chk($sformatf("%s s%0d bo_z_v", tag, SL[i]), 128'(fl[i]), 128'({t.bo, t.z, t.v}));
            chk($sformatf("%s s%0d d_hold", tag, SL[i]), d_w[i], t.d);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " busy"}, 128'(busy_w), 128'd0);
        chk({tag, " done"}, 128'(done_w), 128'd0);
        chk({tag, " bo_z_v"}, 128'({bo_w, z_w, v_w}), 128'd0);
        for (int i = 0; i < 3; i++) chk($sformatf("%s s%0d d", tag, SL[i]), d_w[i], 128'd0);
    endtask

    vec_t vecs [9];
    logic [127:0] k1234 = 128'h1234_5678_9abc_def0_0fed_cba9_8765_4321;

    initial begin
        int n, k;
        vecs[0] = '{128'd5, 128'd3, 1'b0, 128'd2, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{128'd1 << 64, 128'd1, 1'b0, 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{128'd0, 128'd1, 1'b0, ONES, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{k1234, k1234, 1'b0, 128'd0, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{k1234, k1234, 1'b1, ONES, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{128'd1 << 127, 128'd1, 1'b0, ONES >> 1, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{ONES >> 1, ONES, 1'b0, 128'd1 << 127, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{ONES, ONES, 1'b1, ONES, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{128'd0, 128'd0, 1'b1, ONES, 1'b1, 1'b0, 1'b0};

        // reset held with start asserted
        start = 1'b1; a = ONES; b = 128'd1;
        repeat (3) tick;
        chk_zero("reset");
        start = 1'b0; reset_n = 1'b1;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (busy_w != 0 || done_w != 0) n++;
        end
        chk("idle_quiet", 128'(n), 128'd0);

        foreach (vecs[i]) run_op(vecs[i], $sformatf("vec%0d", i));
        for (int r = 0; r < 8; r++) begin
            logic [127:0] x, y;
            x = {$urandom, $urandom, $urandom, $urandom};
            y = (r == 3) ? x : {$urandom, $urandom, $urandom, $urandom};
            run_op(model(x, y, 1'($urandom_range(0, 1))), $sformatf("rnd%0d", r));
        end

        // starts during busy are ignored and inputs are latched (SLICE=32)
        a = 128'd100; b = 128'd1; bi = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        a = ONES; b = 128'd0; start = 1'b1;
        n = 0;
        for (int i = 0; i < 15; i++) begin
            if (i == 2) start = 1'b0;
            tick;
            if (done_w[1]) n++;
            if (done_w[1] && n == 1) chk("ignore d", d_w[1], 128'd99);
        end
        chk("ignore done_count", 128'(n), 128'd1);
        repeat (40) tick;

        // start in the done cycle begins the next operation
        a = 128'd10; b = 128'd3; start = 1'b1;
        tick;
        start = 1'b0;
        k = 0;
        while (!done_w[1] && k < 10) begin tick; k++; end
        chk("b2b first latency", 128'(k), 128'd4);
        chk("b2b first d", d_w[1], 128'd7);
        a = 128'd7; b = 128'd8; start = 1'b1;
        tick;
        start = 1'b0;
        chk("b2b done_pulse", 128'(done_w[1]), 128'd0);
        chk("b2b busy", 128'(busy_w[1]), 128'd1);
        k = 0;
        while (!done_w[1] && k < 10) begin tick; k++; end
        chk("b2b second latency", 128'(k), 128'd4);
        chk("b2b second d", d_w[1], ONES);
        chk("b2b second bo", 128'(bo_w[1]), 128'd1);
        repeat (40) tick;

        // asynchronous reset mid-operation aborts it
        a = 128'd5; b = 128'd3; start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        #2 reset_n = 1'b0;
        #1 chk_zero("abort");
        tick;
        reset_n = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (done_w != 0 || busy_w != 0) n++;
        end
        chk("abort no_done", 128'(n), 128'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
